demux1_2_buf: RTL and testbench
===============================

DEMUX1_2_BUF -- requirements
Module: demux1_2_buf

Interface
REQ-001 Parameter: WIDTH, default 16, data word width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset is synchronous and active-high.
REQ-004 Port: in_data  input  WIDTH  input word.
REQ-005 Port: in_valid  input  1  input word present.
REQ-006 Port: in_ready  output  1  block accepts input word this cycle.
REQ-007 Port: sel  input  1  route select: 1 routes to channel A, 0 routes to channel B; same polarity as the 2:1 mux, so the block is its inverse.
REQ-008 Port: out_a_data  output  WIDTH  channel A head word.
REQ-009 Port: out_a_valid  output  1  channel A word available.
REQ-010 Port: out_a_ready  input  1  channel A consumer takes the word.
REQ-011 Port: out_b_data, out_b_valid, out_b_ready  output/output/input  WIDTH/1/1  channel B, same meaning as channel A.
REQ-012 Port: a_count, b_count  output  2  occupancy of each channel buffer, 0..2.

Function
REQ-013 Each channel SHALL own an independent 2-entry FIFO: 2 storage registers, 1-bit write pointer, 1-bit read pointer, 2-bit count.
REQ-014 Input transfer SHALL occur when in_valid=1 and in_ready=1 at a rising edge; the word is written to the FIFO selected by sel in that cycle.
REQ-015 in_ready SHALL be combinational: 1 when rst=0 and the count of the selected FIFO is < 2; otherwise 0.
REQ-016 A full FIFO SHALL NOT accept a push even if it is popped in the same cycle; no pass-through.
REQ-017 out_x_valid SHALL be 1 when count_x != 0; out_x_data SHALL be the entry at the read pointer.
REQ-018 Output transfer SHALL occur when out_x_valid=1 and out_x_ready=1 at a rising edge; the read pointer toggles and the count decrements.
REQ-019 out_x_ready while out_x_valid=0 SHALL have no effect.
REQ-020 Latency SHALL be exactly one cycle: a word accepted at edge N is visible on out_x_data with out_x_valid=1 after edge N.
REQ-021 Simultaneous push and pop on the same FIFO with count 1 SHALL leave the count at 1 and advance both pointers.
REQ-022 A push to one channel and a pop from the other in the same cycle SHALL be independent.
REQ-023 Per-channel word order SHALL be preserved; there is no ordering relation between channels.
REQ-024 Pointers SHALL wrap 1->0; the count SHALL never exceed 2 or underflow below 0.
REQ-025 A sel change while in_valid=1 and in_ready=0 is permitted; routing uses only the sel value in the accepting cycle.
REQ-026 Data outputs SHALL hold their value while out_x_valid=1 and out_x_ready=0.

Reset
REQ-027 While rst=1 at a rising edge: all counts 0, all pointers 0, all storage registers 0; after that edge out_a_valid=out_b_valid=0, out_a_data=out_b_data=0, a_count=b_count=0.
REQ-028 While rst=1, in_ready SHALL be 0 and no push or pop SHALL occur.
REQ-029 A reset asserted mid-operation SHALL discard all buffered words in both channels; the first accepted word after reset SHALL enter an empty FIFO.

Verification
REQ-030 Reset: hold rst=1 for 2 cycles with in_valid=1 -> in_ready=0, both valid=0, both data=0, counts=0.
REQ-031 Routing: sel=1, data 0x1234, then sel=0, data 0xABCD, both readys=0 -> after edge 2, out_a_data=0x1234, out_b_data=0xABCD, a_count=1, b_count=1.
REQ-032 Full: sel=1, push 0x0001, 0x0002, 0x0003 with out_a_ready=0 -> a_count=2, in_ready=0 on the third cycle, 0x0003 not accepted; switch to sel=0 -> in_ready=1.
REQ-033 Full plus pop: with a_count=2, out_a_ready=1, sel=1, in_valid=1 -> 0x0001 popped, no push that cycle, a_count=1; next cycle push accepted, order 0x0002 then 0x0003.
REQ-034 Streaming: sel=0, 8 consecutive words 0..7, out_b_ready=1 throughout -> b_count stays 1, outputs 0..7 in order one cycle delayed, in_ready constant 1.
REQ-035 Mid-reset: a_count=2, b_count=1, assert rst for 1 cycle -> all counts 0, all valid 0; the next push 0x00FF to A appears at the head of A.

Source files
------------

// File: rtl/demux1_2_buf.sv
// 1:2 demultiplexer with an independent 2-entry FIFO per output channel.
// sel=1 routes the input word to channel A and sel=0 routes it to channel B.
module demux1_2_buf #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sel,
   output logic [WIDTH-1:0] out_a_data,
   output logic             out_a_valid,
   input  logic             out_a_ready,
   output logic [WIDTH-1:0] out_b_data,
   output logic             out_b_valid,
   input  logic             out_b_ready,
   output logic [1:0]       a_count,
   output logic [1:0]       b_count
);

   // Channel index: 0 is A, 1 is B.
   logic [WIDTH-1:0] mem_q [2][2];
   logic [WIDTH-1:0] mem_d [2][2];
   logic             wr_q  [2];
   logic             wr_d  [2];
   logic             rd_q  [2];
   logic             rd_d  [2];
   logic [1:0]       cnt_q [2];
   logic [1:0]       cnt_d [2];
   logic [1:0]       push;
   logic [1:0]       pop;
   logic [1:0]       out_ready;
   logic             tgt;

   assign tgt       = ~sel;
   assign out_ready = {out_b_ready, out_a_ready};

   // A full FIFO refuses the push even when it is popped in the same cycle.
   assign in_ready  = !rst && (cnt_q[tgt] != 2'd2);

   always_comb begin
      push      = '0;
      push[tgt] = in_valid && in_ready;
      for (int c = 0; c < 2; c++) begin
         pop[c]   = out_ready[c] && (cnt_q[c] != 2'd0);
         mem_d[c] = mem_q[c];
         wr_d[c]  = wr_q[c];
         rd_d[c]  = rd_q[c];
         if (push[c]) begin
            mem_d[c][wr_q[c]] = in_data;
            wr_d[c]           = ~wr_q[c];
         end
         if (pop[c]) begin
            rd_d[c] = ~rd_q[c];
         end
         cnt_d[c] = cnt_q[c] + {1'b0, push[c]} - {1'b0, pop[c]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < 2; c++) begin
            // NOTE: storage is cleared too, so the data outputs read 0 after reset.
            mem_q[c][0] <= '0;
            mem_q[c][1] <= '0;
            wr_q[c]     <= 1'b0;
            rd_q[c]     <= 1'b0;
            cnt_q[c]    <= 2'd0;
         end
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign out_a_data  = mem_q[0][rd_q[0]];
   assign out_a_valid = (cnt_q[0] != 2'd0);
   assign a_count     = cnt_q[0];
   assign out_b_data  = mem_q[1][rd_q[1]];
   assign out_b_valid = (cnt_q[1] != 2'd0);
   assign b_count     = cnt_q[1];

endmodule

// File: tb/tb_demux1_2_buf.sv
// Self-checking bench for demux1_2_buf: queue-based channel model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_demux1_2_buf;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             sel = 1'b0;
   logic [WIDTH-1:0] out_a_data;
   logic             out_a_valid;
   logic             out_a_ready = 1'b0;
   logic [WIDTH-1:0] out_b_data;
   logic             out_b_valid;
   logic             out_b_ready = 1'b0;
   logic [1:0]       a_count;
   logic [1:0]       b_count;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   logic [WIDTH-1:0] qa[$];
   logic [WIDTH-1:0] qb[$];

   demux1_2_buf #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sel        (sel),
      .out_a_data (out_a_data),
      .out_a_valid(out_a_valid),
      .out_a_ready(out_a_ready),
      .out_b_data (out_b_data),
      .out_b_valid(out_b_valid),
      .out_b_ready(out_b_ready),
      .a_count    (a_count),
      .b_count    (b_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each channel is a queue of at most two words.
   initial begin
      bit exp_ready, push_e, pop_a, pop_b, sel_s, rst_s;
      logic [WIDTH-1:0] d_s;
      forever begin
         @(negedge clk);
         #2;
         rst_s     = rst;
         sel_s     = sel;
         d_s       = in_data;
         exp_ready = !rst && ((sel ? qa.size() : qb.size()) < 2);
         push_e    = in_valid && exp_ready;
         pop_a     = !rst && (qa.size() != 0) && out_a_ready;
         pop_b     = !rst && (qb.size() != 0) && out_b_ready;
         if (cmp_en) begin
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            check("a_valid", 32'(out_a_valid), 32'(qa.size() != 0));
            check("b_valid", 32'(out_b_valid), 32'(qb.size() != 0));
            check("a_count", 32'(a_count), 32'(qa.size()));
            check("b_count", 32'(b_count), 32'(qb.size()));
            if (qa.size() != 0) check("a_data", 32'(out_a_data), 32'(qa[0]));
            if (qb.size() != 0) check("b_data", 32'(out_b_data), 32'(qb[0]));
         end
         @(posedge clk);
         if (rst_s) begin
            qa.delete();
            qb.delete();
         end else begin
            if (pop_a) void'(qa.pop_front());
            if (pop_b) void'(qb.pop_front());
            if (push_e) begin
               if (sel_s) qa.push_back(d_s);
               else       qb.push_back(d_s);
            end
         end
      end
   end

   task automatic drive(input bit r, input bit v, input bit s, input logic [WIDTH-1:0] d,
                        input bit ra, input bit rb);
      @(negedge clk);
      rst         = r;
      in_valid    = v;
      sel         = s;
      in_data     = d;
      out_a_ready = ra;
      out_b_ready = rb;
   endtask

   task automatic settle;
      #3;
   endtask

   initial begin
      // Reset held two cycles with in_valid asserted.
      drive(1, 1, 1, 16'h5555, 0, 0); settle;
      check("rst_in_ready0", 32'(in_ready), 32'd0);
      drive(1, 1, 0, 16'h6666, 0, 0);
      cmp_en = 1'b1;
      settle;
      check("rst_in_ready1", 32'(in_ready), 32'd0);
      check("rst_a_valid", 32'(out_a_valid), 32'd0);
      check("rst_b_valid", 32'(out_b_valid), 32'd0);
      check("rst_a_data", 32'(out_a_data), 32'd0);
      check("rst_b_data", 32'(out_b_data), 32'd0);
      check("rst_counts", {28'd0, a_count, b_count}, 32'd0);

      // Routing.
      drive(0, 1, 1, 16'h1234, 0, 0);
      drive(0, 1, 0, 16'hABCD, 0, 0);
      drive(0, 0, 0, 16'h0000, 0, 0); settle;
      check("route_a_data", 32'(out_a_data), 32'h1234);
      check("route_b_data", 32'(out_b_data), 32'hABCD);
      check("route_counts", {28'd0, a_count, b_count}, 32'h5);
      drive(1, 0, 0, 16'h0000, 0, 0);

      // Full channel A.
      drive(0, 1, 1, 16'h0001, 0, 0);
      drive(0, 1, 1, 16'h0002, 0, 0);
      drive(0, 1, 1, 16'h0003, 0, 0); settle;
      check("full_a_count", 32'(a_count), 32'd2);
      check("full_in_ready", 32'(in_ready), 32'd0);
      drive(0, 0, 0, 16'h0003, 0, 0); settle;
      check("full_other_ready", 32'(in_ready), 32'd1);
      check("full_b_count", 32'(b_count), 32'd0);

      // Full plus pop: no pass-through push.
      drive(0, 1, 1, 16'h0003, 1, 0); settle;
      check("fp_in_ready", 32'(in_ready), 32'd0);
      check("fp_head1", 32'(out_a_data), 32'h0001);
      drive(0, 1, 1, 16'h0003, 0, 0); settle;
      check("fp_count1", 32'(a_count), 32'd1);
      check("fp_ready1", 32'(in_ready), 32'd1);
      check("fp_head2", 32'(out_a_data), 32'h0002);
      drive(0, 0, 1, 16'h0000, 1, 0); settle;
      check("fp_count2", 32'(a_count), 32'd2);
      drive(0, 0, 1, 16'h0000, 1, 0); settle;
      check("fp_head3", 32'(out_a_data), 32'h0003);
      drive(0, 0, 1, 16'h0000, 0, 0); settle;
      check("fp_empty", 32'(out_a_valid), 32'd0);

      // Streaming through channel B.
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, 0, WIDTH'(i), 0, 1); settle;
         check("stream_ready", 32'(in_ready), 32'd1);
         if (i > 0) begin
            check("stream_data", 32'(out_b_data), 32'(i - 1));
            check("stream_count", 32'(b_count), 32'd1);
         end
      end
      drive(0, 0, 0, 16'h0000, 0, 1); settle;
      check("stream_last", 32'(out_b_data), 32'd7);
      drive(0, 0, 0, 16'h0000, 0, 0); settle;
      check("stream_drained", 32'(b_count), 32'd0);

      // Reset mid-operation.
      drive(0, 1, 1, 16'h0011, 0, 0);
      drive(0, 1, 1, 16'h0022, 0, 0);
      drive(0, 1, 0, 16'h0033, 0, 0);
      drive(1, 1, 1, 16'h0044, 1, 1); settle;
      check("mr_pre_counts", {28'd0, a_count, b_count}, 32'h9);
      check("mr_in_ready", 32'(in_ready), 32'd0);
      drive(0, 1, 1, 16'h00FF, 0, 0); settle;
      check("mr_counts", {28'd0, a_count, b_count}, 32'd0);
      check("mr_valids", {30'd0, out_a_valid, out_b_valid}, 32'd0);
      drive(0, 0, 1, 16'h0000, 0, 0); settle;
      check("mr_head", 32'(out_a_data), 32'h00FF);
      check("mr_a_count", 32'(a_count), 32'd1);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 79) == 0), bit'($urandom_range(0, 3) != 0),
               bit'($urandom_range(0, 1)), WIDTH'($urandom),
               bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 1)));
      end
      drive(0, 0, 0, 16'h0000, 0, 0);
      drive(0, 0, 0, 16'h0000, 0, 0); settle;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
